// File: rtl/wallace_final_cpa.sv
// Chunked carry-propagate adder that resolves the Wallace sum/carry rows into one product.
// Optional early exit once the remaining carry row is zero: WALLACE_CPA_EARLY_EXIT_EN.
module wallace_final_cpa #(
  parameter int WIDTH = 2048,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] sum_vec,
  input  logic [WIDTH-1:0] carry_vec,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] opa, opb, res_nxt;
  logic [IW-1:0]    idx;
  logic             carry_r;
  logic [CHUNK-1:0] a_ch, b_ch, s_ch;
  logic             c, early, finish, accept;
`ifdef WALLACE_CPA_EARLY_EXIT_EN
  logic [WIDTH-1:0] hi_mask;
`endif

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == ADD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k)) begin
        a_ch = opa[k*CHUNK +: CHUNK];
        b_ch = opb[k*CHUNK +: CHUNK];
      end
    end
    {c, s_ch} = {1'b0, a_ch} + {1'b0, b_ch}
              + {{CHUNK{1'b0}}, carry_r};
    res_nxt = result;
    for (int k = 0; k < N; k++) begin
      if (idx == IW'(k))
        res_nxt[k*CHUNK +: CHUNK] = s_ch;
    end
`ifdef WALLACE_CPA_EARLY_EXIT_EN
    hi_mask = '0;
    for (int k = 0; k < N; k++) begin
      if (IW'(k) > idx)
        hi_mask[k*CHUNK +: CHUNK] = '1;
    end
    // nothing left to propagate: upper bits are just the sum row
    early = !c && ((opb & hi_mask) == '0);
    if (early)
      res_nxt = (res_nxt & ~hi_mask) | (opa & hi_mask);
`else
    early = 1'b0;
`endif
    finish = (idx == LAST) || early;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)    state_nxt = ADD;
      ADD:     if (finish)    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa     <= '0;
      opb     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      result  <= '0;
      cout    <= 1'b0;
    end else if (accept) begin
      opa     <= sum_vec;
      opb     <= carry_vec;
      carry_r <= cin;
      idx     <= '0;
    end else if (state == ADD) begin
      result  <= res_nxt;
      carry_r <= c;
      idx     <= idx + IW'(1);
      if (finish) cout <= c;
    end
  end

endmodule

// File: tb/tb_wallace_final_cpa.sv
// Scoreboard bench for wallace_final_cpa: 16/4, 8/8 (single chunk) and 2048/64 instances.
module tb_wallace_final_cpa;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_acc = 0;

  typedef struct {
    logic [2047:0] res;
    logic          co;
    int            lat;
    int            acc;
  } exp_t;

  exp_t qs[$], qu[$], qb[$];
  exp_t es, eu, eb;

  logic        s_iv = 0, s_ir, s_ci = 0, s_ov, s_or = 1, s_co, s_busy;
  logic [15:0] s_sv = '0, s_cv = '0, s_res;
  logic        u_iv = 0, u_ir, u_ci = 0, u_ov, u_or = 1, u_co, u_busy;
  logic [7:0]  u_sv = '0, u_cv = '0, u_res;
  logic          b_iv = 0, b_ir, b_ci = 0, b_ov, b_or = 1, b_co, b_busy;
  logic [2047:0] b_sv = '0, b_cv = '0, b_res;

  wallace_final_cpa #(.WIDTH(16), .CHUNK(4)) d_s (
    .clk(clk), .rst(rst), .in_valid(s_iv), .in_ready(s_ir),
    .sum_vec(s_sv), .carry_vec(s_cv), .cin(s_ci),
    .out_valid(s_ov), .out_ready(s_or), .result(s_res),
    .cout(s_co), .busy(s_busy));

  wallace_final_cpa #(.WIDTH(8), .CHUNK(8)) d_u (
    .clk(clk), .rst(rst), .in_valid(u_iv), .in_ready(u_ir),
    .sum_vec(u_sv), .carry_vec(u_cv), .cin(u_ci),
    .out_valid(u_ov), .out_ready(u_or), .result(u_res),
    .cout(u_co), .busy(u_busy));

  wallace_final_cpa d_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_ir),
    .sum_vec(b_sv), .carry_vec(b_cv), .cin(b_ci),
    .out_valid(b_ov), .out_ready(b_or), .result(b_res),
    .cout(b_co), .busy(b_busy));

  task automatic chk(input string tag, input logic [2047:0] got,
                     input logic [2047:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got[127:0], exp[127:0]);
    end
  endtask

  function automatic exp_t model(input logic [2047:0] s, c,
                                 input logic ci, input int w, ch, acc);
    logic [2048:0] tot;
    logic [2047:0] m, chm;
    logic [64:0]   t;
    logic          cy;
    exp_t          e;
    m   = (2048'(1) << w) - 2048'(1);
    chm = (2048'(1) << ch) - 2048'(1);
    tot = {1'b0, s & m} + {1'b0, c & m} + 2049'(ci);
    e.res = tot[2047:0] & m;
    e.co  = tot[w];
    e.acc = acc;
    e.lat = w / ch;
    cy = ci;
    for (int k = 0; k < w / ch; k++) begin
      t = 65'((s >> (k * ch)) & chm) + 65'((c >> (k * ch)) & chm)
        + 65'(cy);
      cy = t[ch];
`ifdef WALLACE_CPA_EARLY_EXIT_EN
      if (!cy && (((c & m) >> ((k + 1) * ch)) == '0)) begin
        e.lat = k + 1;
        break;
      end
`endif
    end
    return e;
  endfunction

  function automatic logic irdy(input int d);
    case (d)
      0:       return s_ir;
      1:       return u_ir;
      default: return b_ir;
    endcase
  endfunction

  task automatic send(input int d, input logic [2047:0] sv, cv,
                      input logic ci);
    int n = 0;
    @(negedge clk);
    while (!irdy(d) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!irdy(d)) chk("accept_timeout", 0, 1);
    case (d)
      0: begin s_iv = 1; s_sv = sv[15:0]; s_cv = cv[15:0]; s_ci = ci; end
      1: begin u_iv = 1; u_sv = sv[7:0]; u_cv = cv[7:0]; u_ci = ci; end
      default: begin b_iv = 1; b_sv = sv; b_cv = cv; b_ci = ci; end
    endcase
    @(posedge clk);
    #1;
    last_acc = cyc;
    case (d)
      0: begin qs.push_back(model(sv, cv, ci, 16, 4, cyc)); s_iv = 0; end
      1: begin qu.push_back(model(sv, cv, ci, 8, 8, cyc)); u_iv = 0; end
      default: begin
        qb.push_back(model(sv, cv, ci, 2048, 64, cyc));
        b_iv = 0;
      end
    endcase
  endtask

  task automatic drain();
    int n = 0;
    while ((qs.size() + qu.size() + qb.size() != 0 || s_busy || u_busy
            || b_busy || s_ov || u_ov || b_ov) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 0, 1);
  endtask

  logic s_pv = 0, u_pv = 0, b_pv = 0;

  always @(negedge clk) begin
    if (s_ov && !s_pv) begin
      if (qs.size() == 0) chk("s_spurious", 1, 0);
      else begin
        es = qs.pop_front();
        chk("s_result", s_res, es.res);
        chk("s_cout", s_co, es.co);
        chk("s_latency", cyc - es.acc, es.lat);
      end
    end
    s_pv = s_ov;
  end

  always @(negedge clk) begin
    if (u_ov && !u_pv) begin
      if (qu.size() == 0) chk("u_spurious", 1, 0);
      else begin
        eu = qu.pop_front();
        chk("u_result", u_res, eu.res);
        chk("u_cout", u_co, eu.co);
        chk("u_latency", cyc - eu.acc, eu.lat);
      end
    end
    u_pv = u_ov;
  end

  always @(negedge clk) begin
    if (b_ov && !b_pv) begin
      if (qb.size() == 0) chk("b_spurious", 1, 0);
      else begin
        eb = qb.pop_front();
        chk("b_result", b_res, eb.res);
        chk("b_cout", b_co, eb.co);
        chk("b_latency", cyc - eb.acc, eb.lat);
      end
    end
    b_pv = b_ov;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0]   hold;
    logic [1023:0] a, bm;
    logic [2047:0] p, ss, cc, pp, tt;
    int            a1, la, h;

    #1 rst = 1;
    #3;
    chk("rst_out_valid", s_ov, 0);
    chk("rst_busy", s_busy, 0);
    chk("rst_result", s_res, 0);
    chk("rst_cout", s_co, 0);
    chk("rst_in_ready", s_ir, 1);
    chk("rst_b_result", b_res, 0);
    @(negedge clk);
    rst = 0;

    send(0, 16'h00FF, 16'h0001, 0);
    send(0, 16'hFFFF, 16'h0000, 1);
    send(0, 16'hABCD, 16'h0002, 0);
    drain();
    for (int i = 0; i < 4; i++)
      send(0, 2048'($urandom), 2048'($urandom), 1'($urandom));
    drain();

    // back-to-back throughput with out_ready high
    la = model(16'h0F0F, 16'h00F1, 0, 16, 4, 0).lat;
    send(0, 16'h0F0F, 16'h00F1, 0);
    a1 = last_acc;
    send(0, 16'h1357, 16'h2468, 1);
    chk("throughput", last_acc - a1, la + 2);
    drain();

    // backpressure in DONE
    s_or = 0;
    send(0, 16'h5A5A, 16'h0F0F, 1);
    h = 0;
    while (!s_ov && h < 50) begin
      @(negedge clk);
      h++;
    end
    chk("bp_reach_done", s_ov, 1);
    hold = s_res;
    chk("bp_value", hold, 16'h696A);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      s_iv = 1'($urandom);
      s_sv = 16'($urandom);
      chk("bp_in_ready", s_ir, 0);
      chk("bp_hold", s_res, hold);
      chk("bp_valid", s_ov, 1);
      chk("bp_busy", s_busy, 0);
    end
    s_iv = 0;
    @(negedge clk);
    s_or = 1;
    @(posedge clk);
    #1;
    h = cyc;
    chk("bp_release", s_ov, 0);
    send(0, 16'h0101, 16'h1010, 0);
    chk("bp_order", last_acc > h, 1);
    drain();

    // async reset two cycles into ADD
    send(0, 16'hFFFF, 16'h0001, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("abort_busy_pre", s_busy, 1);
    #1 rst = 1;
    #1;
    chk("abort_busy", s_busy, 0);
    chk("abort_valid", s_ov, 0);
    chk("abort_result", s_res, 0);
    chk("abort_cout", s_co, 0);
    chk("abort_in_ready", s_ir, 1);
    qs.delete();
    @(negedge clk);
    rst = 0;
    send(0, 16'h1234, 16'h1111, 0);
    drain();
    chk("post_abort_result", s_res, 16'h2345);

    // single-chunk instance
    send(1, 8'hFF, 8'h01, 0);
    send(1, 8'h12, 8'h34, 1);
    send(1, 8'h80, 8'h7F, 1);
    drain();

    // full width: carry-save reduction of a 1024x1024 product
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) begin
        a[i*32 +: 32]  = $urandom;
        bm[i*32 +: 32] = $urandom;
      end
      p  = 2048'(a) * 2048'(bm);
      ss = '0;
      cc = '0;
      for (int i = 0; i < 1024; i++) begin
        if (bm[i]) begin
          pp = 2048'(a) << i;
          tt = ss ^ cc ^ pp;
          cc = ((ss & cc) | (ss & pp) | (cc & pp)) << 1;
          ss = tt;
        end
      end
      send(2, ss, cc, 0);
      drain();
      chk("b_product", b_res, p);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wallace_final_cpa.md
Name: wallace_final_cpa

Overview:
- Final carry-propagate stage, directly downstream of the Wallace reduction tree in the 1024-bit large multiplier.
- Consumes the two redundant vectors left by the last full-adder layer (sum row and shifted carry row) and resolves them into one binary product.
- Full-width ripple across 2048 bits is infeasible in one cycle, so the block adds CHUNK bits per clock and keeps a registered carry between chunks.
- Valid/ready handshakes sit on both sides.

Parameters:
- WIDTH, 2048, operand/result width in bits (product width of 1024x1024); must be a multiple of CHUNK.
- CHUNK, 64, bits resolved per clock cycle; N = WIDTH/CHUNK cycles per addition.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream presents operands.
- in_ready  output  1  block can accept operands.
- sum_vec  input  WIDTH  Wallace sum row.
- carry_vec  input  WIDTH  Wallace carry row, already left-aligned by the tree.
- cin  input  1  carry into bit 0.
- out_valid  output  1  result and cout are valid.
- out_ready  input  1  downstream accepts result.
- result  output  WIDTH  (sum_vec + carry_vec + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- busy  output  1  high in ADD state.

Behaviour:
- Reset (async, any state): state=IDLE, idx=0, carry reg=0, result=0, cout=0, out_valid=0, busy=0. in_ready=1 once rst deasserts.
- A reset mid-ADD or in DONE aborts the operation. No out_valid is produced for the aborted operands.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, register sum_vec, carry_vec, cin into operand regs; carry reg=cin; idx=0; go to ADD.
  - ADD: in_ready=0, busy=1. Each clock: {c, result[idx*CHUNK +: CHUNK]} = opA chunk + opB chunk + carry reg; carry reg=c; idx++. At idx==N-1, write cout=c and go to DONE.
  - DONE: out_valid=1; result and cout held stable. On out_ready, go to IDLE, out_valid=0.
- Latency:
  - Acceptance at edge k.
  - out_valid rises after edge k+N, i.e. N cycles of ADD.
  - With out_ready held high, throughput is one operation per N+2 cycles.
- Input operands are sampled only at acceptance. Changes on sum_vec/carry_vec/cin afterwards have no effect.
- in_ready is a function of state only, never of in_valid or out_ready. No combinational path from inputs to outputs.
- Backpressure: out_ready low in DONE holds indefinitely; in_valid is ignored (in_ready=0).
- Overflow wraps mod 2^WIDTH; cout exposes the lost bit. For genuine products, cout=0.
- result bits of chunks not yet written in ADD retain the previous operation's values. Result is meaningful only while out_valid=1.
- Boundary: N=1 (WIDTH==CHUNK) is legal; ADD lasts exactly one cycle.

Optional Feature:
- Macro: WALLACE_CPA_EARLY_EXIT_EN.
- Defined:
  - In ADD, after computing chunk idx, check the carry produced (c) and carry_vec bits above chunk idx.
  - If c==0 and all those bits are zero, result's upper bits are loaded from sum_vec's upper bits, cout=0, and the FSM goes to DONE immediately.
  - Latency becomes idx+1 cycles, minimum 1.
- Undefined: always exactly N ADD cycles.
- Result values are identical in both builds; only latency differs.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- sum=16'h00FF, carry=16'h0001, cin=0 -> result=16'h0100, cout=0, out_valid rises exactly 4 cycles after acceptance (macro undefined).
- sum=16'hFFFF, carry=16'h0000, cin=1 -> result=16'h0000, cout=1; carry ripples through all 4 chunks.
- Default params: random 1024x1024 operands reduced by the Wallace tree model -> result equals reference product, cout=0, latency 32 cycles.
- Hold out_ready=0 for 10 cycles in DONE while toggling in_valid/sum_vec -> result stable, in_ready=0; next operation starts only after the out_ready handshake.
- Assert rst two cycles into ADD -> all outputs return to reset values immediately (async); the next operation sum=16'h1234, carry=16'h1111 gives result=16'h2345.
- WALLACE_CPA_EARLY_EXIT_EN defined: sum=16'hABCD, carry=16'h0002, cin=0 -> result=16'hABCF, out_valid after 1 ADD cycle; same vector without macro -> 4 cycles.
